dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 125 ++++++++++++
 tb/tb_dmem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory that answers one load/store at a time after a fixed latency.
//   clk, reset (sync, active-low)
//   req_valid/req_we/req_funct3/req_addr/req_wdata : request, taken when req_valid && req_ready
//   req_ready   : high only while idle
//   resp_valid  : one-cycle completion pulse, LATENCY cycles after acceptance
//   resp_rdata  : extended load data (0 for stores and errors)
//   resp_err    : misaligned or illegal access, qualified by resp_valid
module dmem_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  req_ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);
    localparam int AW = ADDR_WIDTH + 2;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [2:0]              f3_q, f3_d;
    logic [AW-1:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    req_ready_q, req_ready_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    resp_err_q, resp_err_d;
    logic [DATA_WIDTH-1:0]   resp_rdata_q, resp_rdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [2**ADDR_WIDTH];

    logic                    accept, err, wr_en;
    logic [ADDR_WIDTH-1:0]   idx;
    logic [15:0]             lane;
    logic [DATA_WIDTH-1:0]   word, ld_data, mask, rep, wr_word;
    logic                    unused_addr_hi;

    // Address bits above the memory depth are ignored so accesses wrap.
    assign unused_addr_hi = ^req_addr[DATA_WIDTH-1:AW];

    always_comb begin
        accept  = req_valid && req_ready_q;
        we_d    = accept ? req_we : we_q;
        f3_d    = accept ? req_funct3 : f3_q;
        addr_d  = accept ? req_addr[AW-1:0] : addr_q;
        wdata_d = accept ? req_wdata : wdata_q;
        // The *_d request fields equal the captured ones except at acceptance,
        // so they serve both the read on entry to RESP (LATENCY=1) and the write at its end.
        idx     = addr_d[AW-1:2];
        word    = mem_q[idx];
        err     = (f3_d[1:0] == 2'b11) || (f3_d == 3'b110) ||
                  (f3_d[1:0] == 2'b01 && addr_d[0]) ||
                  (f3_d == 3'b010 && addr_d[1:0] != 2'b00) ||
                  (we_d && f3_d[2]);
        lane    = 16'(word >> {addr_d[1:0], 3'b000});
        ld_data = f3_d == 3'b000 ? {{24{lane[7]}}, lane[7:0]} :
                  f3_d == 3'b100 ? {24'b0, lane[7:0]} :
                  f3_d == 3'b001 ? {{16{lane[15]}}, lane} :
                  f3_d == 3'b101 ? {16'b0, lane} : word;
        mask    = f3_d[1:0] == 2'b00 ? 32'hFF << {addr_d[1:0], 3'b000} :
                  f3_d[1:0] == 2'b01 ? 32'hFFFF << {addr_d[1], 4'b0000} : '1;
        rep     = f3_d[1:0] == 2'b00 ? {4{wdata_d[7:0]}} :
                  f3_d[1:0] == 2'b01 ? {2{wdata_d[15:0]}} : wdata_d;
        wr_word = (word & ~mask) | (rep & mask);
        wr_en   = state_q == RESP && we_d && !err;
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d = LATENCY == 1 ? RESP : WAIT;
                cnt_d   = 4'(LATENCY - 1);
            end
            WAIT: begin
                state_d = cnt_q <= 4'd1 ? RESP : WAIT;
                cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d  = state_d == IDLE;
        resp_valid_d = state_d == RESP;
        resp_err_d   = state_d == RESP && err;
        resp_rdata_d = (state_d == RESP && !we_d && !err) ? ld_data : '0;
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        f3_q    <= f3_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Memory is never reset; a store aborted by reset in RESP is dropped.
    always_ff @(posedge clk) begin
        if (reset && wr_en) mem_q[idx] <= wr_word;
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector bench for dmem_responder at LATENCY=2 and LATENCY=1.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        r1_valid = 1'b0, r1_we = 1'b0;
    logic [2:0]  r1_funct3 = 3'b010;
    logic [31:0] r1_addr = '0, r1_wdata = '0;
    logic        r1_ready, r1_rvalid, r1_err;
    logic [31:0] r1_rdata;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err));

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(r1_valid), .req_we(r1_we),
        .req_funct3(r1_funct3), .req_addr(r1_addr), .req_wdata(r1_wdata),
        .req_ready(r1_ready), .resp_valid(r1_rvalid), .resp_rdata(r1_rdata),
        .resp_err(r1_err));

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    localparam int NV = 30;
    vec_t v[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic e,
                          output int lat);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            step();
            lat++;
        end
        rd = resp_rdata;
        e  = resp_err;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        v[0]  = '{1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0};
        v[1]  = '{1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0, 1'b0};
        v[2]  = '{1'b0, 3'b000, 32'h11, 32'h0, 32'h0000007F, 1'b0};
        v[3]  = '{1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0};
        v[4]  = '{1'b0, 3'b100, 32'h12, 32'h0, 32'h000000FF, 1'b0};
        v[5]  = '{1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0};
        v[6]  = '{1'b0, 3'b101, 32'h10, 32'h0, 32'h00007F01, 1'b0};
        v[7]  = '{1'b0, 3'b001, 32'h10, 32'h0, 32'h00007F01, 1'b0};
        v[8]  = '{1'b0, 3'b100, 32'h13, 32'h0, 32'h00000080, 1'b0};
        v[9]  = '{1'b0, 3'b000, 32'h10, 32'h0, 32'h00000001, 1'b0};
        v[10] = '{1'b1, 3'b010, 32'h20, 32'h11223344, 32'h0, 1'b0};
        v[11] = '{1'b1, 3'b000, 32'h21, 32'hFFFFFFAA, 32'h0, 1'b0};
        v[12] = '{1'b0, 3'b010, 32'h20, 32'h0, 32'h1122AA44, 1'b0};
        v[13] = '{1'b1, 3'b001, 32'h22, 32'h5566BEEF, 32'h0, 1'b0};
        v[14] = '{1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0};
        v[15] = '{1'b0, 3'b010, 32'h22, 32'h0, 32'h0, 1'b1};
        v[16] = '{1'b1, 3'b001, 32'h23, 32'h0000FFFF, 32'h0, 1'b1};
        v[17] = '{1'b1, 3'b100, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1};
        v[18] = '{1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1};
        v[19] = '{1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 1'b1};
        v[20] = '{1'b0, 3'b001, 32'h21, 32'h0, 32'h0, 1'b1};
        v[21] = '{1'b1, 3'b101, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1};
        v[22] = '{1'b1, 3'b111, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1};
        v[23] = '{1'b0, 3'b010, 32'h20, 32'h0, 32'hBEEFAA44, 1'b0};
        v[24] = '{1'b1, 3'b010, 32'h00001040, 32'hCAFEF00D, 32'h0, 1'b0};
        v[25] = '{1'b0, 3'b010, 32'h80000040, 32'h0, 32'hCAFEF00D, 1'b0};
        v[26] = '{1'b1, 3'b000, 32'h43, 32'h00000012, 32'h0, 1'b0};
        v[27] = '{1'b0, 3'b010, 32'h40, 32'h0, 32'h12FEF00D, 1'b0};
        v[28] = '{1'b0, 3'b101, 32'h42, 32'h0, 32'h000012FE, 1'b0};
        v[29] = '{1'b0, 3'b000, 32'h42, 32'h0, 32'hFFFFFFFE, 1'b0};

        // Reset state
        step(); step(); step();
        chk("rst_ready", req_ready, 0);
        chk("rst_valid", resp_valid, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_rdata", resp_rdata, 0);
        reset = 1'b1;
        step();
        chk("ready_after_release", req_ready, 1);

        // sw 0x10 timing, cycle by cycle
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
        step();
        req_valid = 1'b0;
        chk("c1_ready", req_ready, 0);
        chk("c1_valid", resp_valid, 0);
        step();
        chk("c2_ready", req_ready, 0);
        chk("c2_valid", resp_valid, 1);
        chk("c2_rdata", resp_rdata, 0);
        chk("c2_err", resp_err, 0);
        step();
        chk("c3_ready", req_ready, 1);
        chk("c3_valid", resp_valid, 0);

        for (int i = 0; i < NV; i++) begin
            do_req(v[i].we, v[i].f3, v[i].addr, v[i].wdata, rd, e, lat);
            chk($sformatf("vec%0d_rdata", i), rd, v[i].rdata);
            chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, v[i].err});
            chk($sformatf("vec%0d_latency", i), lat, 2);
            chk($sformatf("vec%0d_ready", i), req_ready, 1);
        end

        // Request inputs changed while busy are ignored
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        step();
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h0;
        chk("busy_c1_valid", resp_valid, 0);
        step();
        chk("busy_c2_valid", resp_valid, 1);
        chk("busy_c2_rdata", resp_rdata, 32'h80FF7F01);
        req_valid = 1'b0;
        step();
        do_req(1'b0, 3'b010, 32'h20, 32'h0, rd, e, lat);
        chk("busy_store_ignored", rd, 32'hBEEFAA44);

        // Reset during WAIT aborts the store
        do_req(1'b1, 3'b010, 32'h30, 32'h12345678, rd, e, lat);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hBADBAD00;
        step();
        req_valid = 1'b0;
        reset = 1'b0;
        step();
        chk("abort_wait_valid", resp_valid, 0);
        chk("abort_wait_ready", req_ready, 0);
        reset = 1'b1;
        step();
        chk("abort_wait_ready_after", req_ready, 1);
        chk("abort_wait_no_valid", resp_valid, 0);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, e, lat);
        chk("abort_wait_old_data", rd, 32'h12345678);

        // Reset during RESP drops the pending store
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BAD0BAD;
        step();
        req_valid = 1'b0;
        step();
        chk("abort_resp_in_resp", resp_valid, 1);
        reset = 1'b0;
        step();
        chk("abort_resp_valid", resp_valid, 0);
        reset = 1'b1;
        step();
        chk("abort_resp_ready", req_ready, 1);
        do_req(1'b0, 3'b010, 32'h30, 32'h0, rd, e, lat);
        chk("abort_resp_old_data", rd, 32'h12345678);

        // LATENCY=1 back-to-back with req_valid held high
        chk("l1_ready_start", r1_ready, 1);
        r1_valid = 1'b1; r1_we = 1'b1; r1_funct3 = 3'b010; r1_addr = 32'h8; r1_wdata = 32'hA5A5A5A5;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("l1_ready_%0d", i), r1_ready, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("l1_valid_%0d", i), r1_rvalid, (i % 2 == 1) ? 32'd1 : 32'd0);
        end
        r1_we = 1'b0;
        step();
        r1_valid = 1'b0;
        chk("l1_load_valid", r1_rvalid, 1);
        chk("l1_load_rdata", r1_rdata, 32'hA5A5A5A5);
        chk("l1_load_err", r1_err, 0);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
